// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy drive sequencer and the track encoder:
// drive state encoding, geometry constants and the speed-zone lookup.
package floppy_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SPINUP,
        ST_RUN,
        ST_STEP,
        ST_SETTLE
    } drive_state_e;

    localparam int unsigned SECTOR_BYTES = 782;
    localparam int unsigned MAX_TRACK    = 79;

    // Sectors per track for the speed zone given by track[6:4].
    function automatic logic [3:0] spt_for_zone(input logic [2:0] zone);
        case (zone)
            3'd0:    return 4'd12;
            3'd1:    return 4'd11;
            3'd2:    return 4'd10;
            3'd3:    return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/floppy_byte_pacer.sv
// Byte-rate divider and revolution position counter; produces the byte tick
// and the once-per-revolution index pulse.
module floppy_byte_pacer
    import floppy_pkg::*;
#(
    parameter int unsigned CLK_PER_BYTE = 16,
    parameter int unsigned SECTOR_BYTES = floppy_pkg::SECTOR_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] zone,
    output logic       tick,
    output logic       index
);

    localparam int unsigned DIV_W = $clog2(CLK_PER_BYTE);

    logic [DIV_W-1:0] div_q, div_d;
    logic [13:0]      rev_q, rev_d;
    logic [13:0]      rev_last;

    assign tick     = (div_q == DIV_W'(CLK_PER_BYTE - 1));
    assign rev_last = 14'(int'(spt_for_zone(zone)) * SECTOR_BYTES - 1);
    assign index    = tick && run && (rev_q == '0);

    // Held at zero outside RUN; an encoder reset pulse for a side change
    // leaves the revolution position untouched.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        rev_d = rev_q;
        if (!run) begin
            rev_d = '0;
        end else if (tick) begin
            rev_d = (rev_q == rev_last) ? '0 : rev_q + 14'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            rev_q <= '0;
        end else begin
            div_q <= div_d;
            rev_q <= rev_d;
        end
    end

endmodule

// File: rtl/floppy_drive_sequencer.sv
// Per-drive sequencer: motor spin-up, head stepping with settle, track/side
// position, and encoder pacing/reset for one floppy drive.
module floppy_drive_sequencer
    import floppy_pkg::*;
#(
    parameter int unsigned CLK_PER_BYTE = 16,
    parameter int unsigned SPINUP_BYTES = 4096,
    parameter int unsigned SETTLE_BYTES = 600,
    parameter int unsigned SECTOR_BYTES = floppy_pkg::SECTOR_BYTES,
    parameter int unsigned MAX_TRACK    = floppy_pkg::MAX_TRACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inserted,
    input  logic       motor_req,
    input  logic       step_req,
    input  logic       step_dir,
    input  logic       side_sel,
    output logic       enc_ready,
    output logic       enc_rst,
    output logic [6:0] track,
    output logic       side,
    output logic       track0,
    output logic       busy,
    output logic       drive_ready,
    output logic       index
);

    localparam int unsigned CNT_MAX = (SPINUP_BYTES > SETTLE_BYTES) ? SPINUP_BYTES : SETTLE_BYTES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    drive_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       track_q, track_d;
    logic [1:0]       sync_q, sync_d;
    logic             side_q, side_d;
    logic             enc_rst_q, enc_rst_d;
    logic             track0_q, track0_d;
    logic             busy_q, busy_d;
    logic             drive_ready_q, drive_ready_d;

    logic       tick;
    logic       step_ok;
    logic       power_ok;
    logic [6:0] stepped_track;

    floppy_byte_pacer #(
        .CLK_PER_BYTE (CLK_PER_BYTE),
        .SECTOR_BYTES (SECTOR_BYTES)
    ) u_pacer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == ST_RUN),
        .zone  (track_q[6:4]),
        .tick  (tick),
        .index (index)
    );

    assign step_ok  = step_req && inserted;
    assign power_ok = inserted && motor_req;

    always_comb begin
        stepped_track = track_q;
        if (step_dir) begin
            if (track_q != '0) stepped_track = track_q - 7'd1;
        end else begin
            if (track_q != 7'(MAX_TRACK)) stepped_track = track_q + 7'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        track_d = track_q;
        sync_d  = {sync_q[0], 1'b1};
        side_d  = side_sel;

        if (state_q == ST_OFF) begin
            if (step_ok) track_d = stepped_track;
            if (power_ok && sync_q[1]) begin
                state_d = ST_SPINUP;
                cnt_d   = '0;
            end
        end else if (!power_ok) begin
            // Motor drop or eject wins over everything, but a coincident
            // step still moves the head as it would in OFF.
            state_d = ST_OFF;
            cnt_d   = '0;
            if (step_ok) track_d = stepped_track;
        end else if (state_q == ST_STEP) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
        end else if (step_ok) begin
            state_d = ST_STEP;
            track_d = stepped_track;
        end else if (tick && state_q == ST_SPINUP) begin
            if (cnt_q == CNT_W'(SPINUP_BYTES - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (tick && state_q == ST_SETTLE) begin
            if (cnt_q == CNT_W'(SETTLE_BYTES - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        enc_rst_d     = (state_d != ST_RUN) || (state_q == ST_RUN && side_sel != side_q);
        busy_d        = (state_d == ST_STEP) || (state_d == ST_SETTLE);
        drive_ready_d = (state_d == ST_RUN);
        track0_d      = (track_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            track_q       <= '0;
            sync_q        <= '0;
            side_q        <= 1'b0;
            enc_rst_q     <= 1'b1;
            track0_q      <= 1'b1;
            busy_q        <= 1'b0;
            drive_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            track_q       <= track_d;
            sync_q        <= sync_d;
            side_q        <= side_d;
            enc_rst_q     <= enc_rst_d;
            track0_q      <= track0_d;
            busy_q        <= busy_d;
            drive_ready_q <= drive_ready_d;
        end
    end

    assign enc_ready   = tick && (state_q == ST_RUN);
    assign enc_rst     = enc_rst_q;
    assign track       = track_q;
    assign side        = side_q;
    assign track0      = track0_q;
    assign busy        = busy_q;
    assign drive_ready = drive_ready_q;

endmodule

// File: tb/tb_floppy_drive_sequencer.sv
// Directed bench for floppy_drive_sequencer with short spin-up/settle and
// the real sector geometry so index periods match the zone table.
module tb_floppy_drive_sequencer;

    localparam int unsigned CPB    = 4;
    localparam int unsigned SPIN   = 8;
    localparam int unsigned SETTLE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       inserted = 1'b0;
    logic       motor_req = 1'b0;
    logic       step_req = 1'b0;
    logic       step_dir = 1'b0;
    logic       side_sel = 1'b0;
    logic       enc_ready;
    logic       enc_rst;
    logic [6:0] track;
    logic       side;
    logic       track0;
    logic       busy;
    logic       drive_ready;
    logic       index;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    floppy_drive_sequencer #(
        .CLK_PER_BYTE (CPB),
        .SPINUP_BYTES (SPIN),
        .SETTLE_BYTES (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inserted    (inserted),
        .motor_req   (motor_req),
        .step_req    (step_req),
        .step_dir    (step_dir),
        .side_sel    (side_sel),
        .enc_ready   (enc_ready),
        .enc_rst     (enc_rst),
        .track       (track),
        .side        (side),
        .track0      (track0),
        .busy        (busy),
        .drive_ready (drive_ready),
        .index       (index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx, input logic [6:0] exp_track);
        check({pfx, "_enc_ready"}, 32'(enc_ready), 0);
        check({pfx, "_enc_rst"}, 32'(enc_rst), 1);
        check({pfx, "_track"}, 32'(track), 32'(exp_track));
        check({pfx, "_side"}, 32'(side), 0);
        check({pfx, "_track0"}, 32'(track0), 1);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_drive_ready"}, 32'(drive_ready), 0);
        check({pfx, "_index"}, 32'(index), 0);
    endtask

    task automatic do_step(input logic dir);
        step_dir = dir;
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        clk1();
        clk1();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 500) begin
            clk1();
            g++;
        end
        check("settle_done", 32'(busy), 0);
    endtask

    task automatic wait_run();
        int g = 0;
        while (!drive_ready && g < 300) begin
            clk1();
            g++;
        end
        check("run_reached", 32'(drive_ready), 1);
    endtask

    // Ticks from one index to the next; optionally flips side_sel at a tick.
    task automatic index_gap(input int toggle_at, output int gap, output int rst_hi,
                             output logic side_at_rst);
        int g = 0;
        gap = 0;
        rst_hi = 0;
        side_at_rst = 1'b0;
        while (!index && g < 100) begin
            clk1();
            g++;
        end
        check("index_seen", 32'(index), 1);
        g = 0;
        do begin
            clk1();
            g++;
            if (enc_ready) gap++;
            if (enc_rst) begin
                rst_hi++;
                side_at_rst = side;
            end
            if (enc_ready && gap == toggle_at) side_sel = ~side_sel;
        end while (!index && g < 40000);
    endtask

    initial begin
        int   n;
        int   gap;
        int   rst_hi;
        logic side_at;
        logic all_hi;

        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("reset", 7'd0);

        inserted = 1'b1;
        repeat (3) clk1();
        rst_n = 1'b1;
        repeat (5) clk1();
        check("off_enc_rst", 32'(enc_rst), 1);
        check("off_ready", 32'(drive_ready), 0);

        // Spin-up: 8 ticks, first of which lands 1..CPB clocks after entry.
        motor_req = 1'b1;
        n = 0;
        do begin
            clk1();
            n++;
        end while (enc_rst && n < 200);
        check("spinup_len", 32'(n >= int'((SPIN - 1) * CPB + 2) && n <= int'(SPIN * CPB + 1)), 1);
        check("run_ready", 32'(drive_ready), 1);
        n = 0;
        while (!enc_ready && n < 50) begin
            clk1();
            n++;
        end
        check("first_ready_lat", 32'(n >= 1 && n <= int'(CPB)), 1);
        check("first_index", 32'(index), 1);

        index_gap(0, gap, rst_hi, side_at);
        check("rev_trk0", 32'(gap), 12 * 782);
        check("rev_trk0_rst", 32'(rst_hi), 0);

        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                clk1();
                n++;
            end while (!enc_ready && n < 50);
            check("ready_period", 32'(n), 32'(CPB));
        end

        // Two inward steps three ticks apart.
        check("busy_idle", 32'(busy), 0);
        step_dir = 1'b0;
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        check("step1_track", 32'(track), 1);
        check("step1_busy", 32'(busy), 1);
        check("step1_rst", 32'(enc_rst), 1);
        all_hi = 1'b1;
        repeat (3 * CPB) begin
            clk1();
            if (!busy || !enc_rst) all_hi = 1'b0;
        end
        check("between_steps", 32'(all_hi), 1);
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        check("step2_track", 32'(track), 2);
        n = 0;
        all_hi = 1'b1;
        while (busy && n < 200) begin
            if (!enc_rst) all_hi = 1'b0;
            n++;
            clk1();
        end
        // One STEP clock plus SETTLE ticks, the first 1..CPB clocks in.
        check("settle_len", 32'(n >= int'((SETTLE - 1) * CPB + 2) && n <= int'(SETTLE * CPB + 1)), 1);
        check("settle_rst", 32'(all_hi), 1);
        check("settle_run", 32'(drive_ready), 1);
        check("settle_rst_rel", 32'(enc_rst), 0);

        for (int k = 0; k < 14; k++) do_step(1'b0);
        wait_idle();
        check("trk16", 32'(track), 16);
        index_gap(100, gap, rst_hi, side_at);
        check("rev_trk16", 32'(gap), 11 * 782);
        check("side_rst_pulses", 32'(rst_hi), 1);
        check("side_at_pulse", 32'(side_at), 1);
        check("side_now", 32'(side), 1);

        // Saturation at both ends.
        for (int k = 0; k < 16; k++) do_step(1'b1);
        wait_idle();
        check("trk0_back", 32'(track), 0);
        step_dir = 1'b1;
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        check("sat0_track", 32'(track), 0);
        check("sat0_track0", 32'(track0), 1);
        check("sat0_busy", 32'(busy), 1);
        wait_idle();
        for (int k = 0; k < 85; k++) do_step(1'b0);
        wait_idle();
        check("sat79_track", 32'(track), 79);
        check("sat79_track0", 32'(track0), 0);

        // Eject during settle.
        do_step(1'b1);
        check("eject_pre_busy", 32'(busy), 1);
        inserted = 1'b0;
        clk1();
        check("eject_busy", 32'(busy), 0);
        check("eject_rst", 32'(enc_rst), 1);
        check("eject_ready", 32'(drive_ready), 0);
        check("eject_track", 32'(track), 78);
        step_dir = 1'b0;
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        check("nodisk_step", 32'(track), 78);

        // Step in OFF moves the head with no settle.
        inserted = 1'b1;
        motor_req = 1'b0;
        step_req = 1'b1;
        clk1();
        step_req = 1'b0;
        check("off_step_track", 32'(track), 79);
        check("off_step_busy", 32'(busy), 0);

        // Step coinciding with motor drop in RUN.
        motor_req = 1'b1;
        wait_run();
        step_dir = 1'b1;
        step_req = 1'b1;
        motor_req = 1'b0;
        clk1();
        step_req = 1'b0;
        check("drop_step_track", 32'(track), 78);
        check("drop_step_ready", 32'(drive_ready), 0);
        check("drop_step_busy", 32'(busy), 0);
        check("drop_step_rst", 32'(enc_rst), 1);

        // Asynchronous reset mid-RUN.
        motor_req = 1'b1;
        wait_run();
        repeat (7) clk1();
        side_sel = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrun", 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
